tdm_demux4: RTL and testbench

Four-channel time-division demultiplexer: the receive-side counterpart of the team's 4:1 multiplexer. It accepts a time-multiplexed stream of W-bit beats, one channel per beat in slot order 0,1,2,3, with frame start marked on slot 0. It distributes the beats into four parallel channel outputs and signals each completed frame. It sits after the serial/TDM link and feeds per-channel logic.

---
 rtl/tdm_demux4.sv | 127 ++++++++++++
 tb/tb_tdm_demux4.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tdm_demux4.sv
// rtl/tdm_demux4.sv - four-channel TDM demultiplexer with frame lock tracking
module tdm_demux4 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    input  logic         din_sof,
    output logic [W-1:0] q0,
    output logic [W-1:0] q1,
    output logic [W-1:0] q2,
    output logic [W-1:0] q3,
    output logic         frame_valid,
    output logic         locked,
    output logic         sync_err,
    output logic [1:0]   slot
);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    state_t       state, state_n;
    logic [1:0]   slot_n;
    logic [W-1:0] s0, s1, s2;
    logic [W-1:0] s0_n, s1_n, s2_n;
    logic [W-1:0] q0_n, q1_n, q2_n, q3_n;
    logic         frame_valid_n;
    logic         sync_err_n;

    // State, slot counter, staging and output registers; every output is a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= HUNT;
            slot        <= 2'd0;
            s0          <= '0;
            s1          <= '0;
            s2          <= '0;
            q0          <= '0;
            q1          <= '0;
            q2          <= '0;
            q3          <= '0;
            frame_valid <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            state       <= state_n;
            slot        <= slot_n;
            s0          <= s0_n;
            s1          <= s1_n;
            s2          <= s2_n;
            q0          <= q0_n;
            q1          <= q1_n;
            q2          <= q2_n;
            q3          <= q3_n;
            frame_valid <= frame_valid_n;
            sync_err    <= sync_err_n;
        end
    end

    // Next-state: non-beat cycles hold everything except the two pulses.
    // An sof in the middle of a frame restarts the frame at slot 0 without
    // losing lock; a missing sof at slot 0 drops the beat and falls back to HUNT.
    always_comb begin
        state_n       = state;
        slot_n        = slot;
        s0_n          = s0;
        s1_n          = s1;
        s2_n          = s2;
        q0_n          = q0;
        q1_n          = q1;
        q2_n          = q2;
        q3_n          = q3;
        frame_valid_n = 1'b0;
        sync_err_n    = 1'b0;
        if (din_valid) begin
            case (state)
                HUNT: begin
                    if (din_sof) begin
                        s0_n    = din;
                        slot_n  = 2'd1;
                        state_n = LOCK;
                    end
                end
                LOCK: begin
                    if (din_sof) begin
                        sync_err_n = (slot != 2'd0);
                        s0_n       = din;
                        slot_n     = 2'd1;
                    end else begin
                        case (slot)
                            2'd0: begin
                                sync_err_n = 1'b1;
                                state_n    = HUNT;
                                slot_n     = 2'd0;
                            end
                            2'd1: begin
                                s1_n   = din;
                                slot_n = 2'd2;
                            end
                            2'd2: begin
                                s2_n   = din;
                                slot_n = 2'd3;
                            end
                            default: begin
                                q0_n          = s0;
                                q1_n          = s1;
                                q2_n          = s2;
                                q3_n          = din;
                                frame_valid_n = 1'b1;
                                slot_n        = 2'd0;
                            end
                        endcase
                    end
                end
                default: begin
                    state_n = HUNT;
                    slot_n  = 2'd0;
                end
            endcase
        end
    end

    assign locked = (state == LOCK);

endmodule

// File: tb/tb_tdm_demux4.sv
// tb/tb_tdm_demux4.sv - directed self-checking bench for tdm_demux4
module tb_tdm_demux4;

    logic       clk;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_sof;
    logic [7:0] q0, q1, q2, q3;
    logic       frame_valid;
    logic       locked;
    logic       sync_err;
    logic [1:0] slot;

    int n_checks = 0;
    int n_fail   = 0;

    tdm_demux4 #(.W(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .din_valid   (din_valid),
        .din_sof     (din_sof),
        .q0          (q0),
        .q1          (q1),
        .q2          (q2),
        .q3          (q3),
        .frame_valid (frame_valid),
        .locked      (locked),
        .sync_err    (sync_err),
        .slot        (slot)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Presents one cycle of input at a falling edge and returns at the next
    // falling edge, so outputs then reflect the rising edge in between.
    task automatic send(input logic v, input logic s, input logic [7:0] d);
        din       = d;
        din_valid = v;
        din_sof   = s;
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({q0, q1, q2, q3} !== 32'h0) begin
            n_fail++; $display("FAIL reset_q: got %h expected %h", {q0, q1, q2, q3}, 32'h0);
        end
        n_checks++;
        if ({frame_valid, locked, sync_err, slot} !== 5'b0) begin
            n_fail++; $display("FAIL reset_ctl: got %b expected %b", {frame_valid, locked, sync_err, slot}, 5'b0);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_aligned();
        send(1, 1, 8'h11);
        n_checks++;
        if ({locked, slot, frame_valid} !== {1'b1, 2'd1, 1'b0}) begin
            n_fail++; $display("FAIL aligned_lock: got %b expected %b", {locked, slot, frame_valid}, 4'b1010);
        end
        send(1, 0, 8'h22);
        send(1, 0, 8'h33);
        n_checks++;
        if (slot !== 2'd3) begin
            n_fail++; $display("FAIL aligned_slot3: got %0d expected 3", slot);
        end
        send(1, 0, 8'h44);
        n_checks++;
        if ({q0, q1, q2, q3} !== 32'h11223344) begin
            n_fail++; $display("FAIL aligned_q: got %h expected %h", {q0, q1, q2, q3}, 32'h11223344);
        end
        n_checks++;
        if ({frame_valid, locked, sync_err, slot} !== {1'b1, 1'b1, 1'b0, 2'd0}) begin
            n_fail++; $display("FAIL aligned_ctl: got %b expected %b", {frame_valid, locked, sync_err, slot}, 5'b11000);
        end
        send(0, 0, 8'h00);
        n_checks++;
        if ({frame_valid, {q0, q1, q2, q3}} !== {1'b0, 32'h11223344}) begin
            n_fail++; $display("FAIL aligned_pulse_end: got %b/%h expected 0/11223344", frame_valid, {q0, q1, q2, q3});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  d   [12] = '{8'hA0, 8'h00, 8'hA1, 8'hA2, 8'h00, 8'h00, 8'hA3, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'h00};
        logic        v   [12] = '{1, 0, 1, 1, 0, 0, 1, 1, 1, 1, 1, 0};
        logic        s   [12] = '{1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
        logic        fv  [12] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0};
        logic [31:0] eq  [12] = '{32'h11223344, 32'h11223344, 32'h11223344, 32'h11223344,
                                  32'h11223344, 32'h11223344, 32'hA0A1A2A3, 32'hA0A1A2A3,
                                  32'hA0A1A2A3, 32'hA0A1A2A3, 32'hB0B1B2B3, 32'hB0B1B2B3};
        for (int i = 0; i < 12; i++) begin
            send(v[i], s[i], d[i]);
            n_checks++;
            if ({frame_valid, sync_err, {q0, q1, q2, q3}} !== {fv[i], 1'b0, eq[i]}) begin
                n_fail++;
                $display("FAIL b2b_step%0d: got fv=%b err=%b q=%h expected fv=%b err=0 q=%h",
                         i, frame_valid, sync_err, {q0, q1, q2, q3}, fv[i], eq[i]);
            end
        end
    endtask

    task automatic test_garbage();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        send(1, 0, 8'h55);
        send(1, 0, 8'h66);
        n_checks++;
        if ({locked, slot, sync_err, {q0, q1, q2, q3}} !== {1'b0, 2'd0, 1'b0, 32'h0}) begin
            n_fail++; $display("FAIL garbage_ignored: got lk=%b slot=%0d err=%b q=%h expected 0/0/0/0", locked, slot, sync_err, {q0, q1, q2, q3});
        end
        send(1, 1, 8'h01);
        n_checks++;
        if (locked !== 1'b1) begin
            n_fail++; $display("FAIL garbage_lock: got %b expected 1", locked);
        end
        send(1, 0, 8'h02);
        send(1, 0, 8'h03);
        send(1, 0, 8'h04);
        n_checks++;
        if ({frame_valid, sync_err, {q0, q1, q2, q3}} !== {1'b1, 1'b0, 32'h01020304}) begin
            n_fail++; $display("FAIL garbage_frame: got fv=%b err=%b q=%h expected 1/0/01020304", frame_valid, sync_err, {q0, q1, q2, q3});
        end
    endtask

    task automatic test_early_sof();
        send(1, 1, 8'h10);
        send(1, 0, 8'h20);
        send(1, 1, 8'h30);
        n_checks++;
        if ({sync_err, frame_valid, locked, slot} !== {1'b1, 1'b0, 1'b1, 2'd1}) begin
            n_fail++; $display("FAIL early_err: got %b expected %b", {sync_err, frame_valid, locked, slot}, 5'b10101);
        end
        send(1, 0, 8'h40);
        n_checks++;
        if (sync_err !== 1'b0) begin
            n_fail++; $display("FAIL early_err_width: got %b expected 0", sync_err);
        end
        send(1, 0, 8'h50);
        n_checks++;
        if ({frame_valid, {q0, q1, q2, q3}} !== {1'b0, 32'h01020304}) begin
            n_fail++; $display("FAIL early_hold: got fv=%b q=%h expected 0/01020304", frame_valid, {q0, q1, q2, q3});
        end
        send(1, 0, 8'h60);
        n_checks++;
        if ({frame_valid, sync_err, {q0, q1, q2, q3}} !== {1'b1, 1'b0, 32'h30405060}) begin
            n_fail++; $display("FAIL early_frame: got fv=%b err=%b q=%h expected 1/0/30405060", frame_valid, sync_err, {q0, q1, q2, q3});
        end
    endtask

    task automatic test_missing_sof();
        send(1, 1, 8'h01);
        send(1, 0, 8'h02);
        send(1, 0, 8'h03);
        send(1, 0, 8'h04);
        send(1, 0, 8'h77);
        n_checks++;
        if ({sync_err, frame_valid, locked, slot, {q0, q1, q2, q3}} !== {1'b1, 1'b0, 1'b0, 2'd0, 32'h01020304}) begin
            n_fail++; $display("FAIL missing_err: got err=%b fv=%b lk=%b slot=%0d q=%h expected 1/0/0/0/01020304",
                               sync_err, frame_valid, locked, slot, {q0, q1, q2, q3});
        end
        send(1, 1, 8'h05);
        n_checks++;
        if ({sync_err, locked} !== 2'b01) begin
            n_fail++; $display("FAIL missing_relock: got %b expected 01", {sync_err, locked});
        end
        send(1, 0, 8'h06);
        send(1, 0, 8'h07);
        send(1, 0, 8'h08);
        n_checks++;
        if ({frame_valid, {q0, q1, q2, q3}} !== {1'b1, 32'h05060708}) begin
            n_fail++; $display("FAIL missing_frame: got fv=%b q=%h expected 1/05060708", frame_valid, {q0, q1, q2, q3});
        end
    endtask

    task automatic test_async_reset();
        send(1, 1, 8'hC0);
        send(1, 0, 8'hC1);
        n_checks++;
        if ({locked, slot} !== {1'b1, 2'd2}) begin
            n_fail++; $display("FAIL areset_pre: got %b expected 110", {locked, slot});
        end
        #2 rst = 1'b1;
        #1;
        n_checks++;
        if ({locked, slot, frame_valid, sync_err, {q0, q1, q2, q3}} !== 37'h0) begin
            n_fail++; $display("FAIL areset_now: got lk=%b slot=%0d fv=%b err=%b q=%h expected all 0",
                               locked, slot, frame_valid, sync_err, {q0, q1, q2, q3});
        end
        @(negedge clk);
        rst = 1'b0;
        send(1, 0, 8'hC2);
        n_checks++;
        if ({locked, slot, sync_err, {q0, q1, q2, q3}} !== 35'h0) begin
            n_fail++; $display("FAIL areset_post: got lk=%b slot=%0d err=%b q=%h expected all 0",
                               locked, slot, sync_err, {q0, q1, q2, q3});
        end
    endtask

    // Runs the scenarios in order; each task leaves the bench at a falling edge.
    initial begin
        rst       = 1'b1;
        din       = 8'h00;
        din_valid = 1'b0;
        din_sof   = 1'b0;
        test_reset();
        test_aligned();
        test_back_to_back();
        test_garbage();
        test_early_sof();
        test_missing_sof();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
